// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate unit: opcodes, immediate kinds,
// and the parameter legality check used by the pipeline top.
package imm_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned KIND_W = 3;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [KIND_W-1:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_kind_e;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decoder: raw instruction word -> extended immediate, kind and
// reserved-shamt flag. Built at 64 bits internally and truncated to XLEN.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INST_W-1:0] i_inst,
    output logic [XLEN-1:0]   o_imm_c,
    output imm_kind_e         o_kind_c,
    output logic              o_illegal_c
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_is_shift;
    logic        w_s;
    logic [63:0] w_imm64;

    assign w_opc      = i_inst[6:0];
    assign w_f3       = i_inst[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_s        = i_inst[31];

    always_comb begin
        w_imm64     = '0;
        o_kind_c    = IMM_NONE;
        o_illegal_c = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                o_kind_c = IMM_I;
                w_imm64  = {{52{w_s}}, i_inst[31:20]};
            end
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    o_kind_c = IMM_SHAMT;
                    if (XLEN == 64) begin
                        w_imm64 = 64'(i_inst[25:20]);
                    end else begin
                        w_imm64     = 64'(i_inst[24:20]);
                        o_illegal_c = i_inst[25];
                    end
                end else begin
                    o_kind_c = IMM_I;
                    w_imm64  = {{52{w_s}}, i_inst[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                // Word ops only exist on RV64; on RV32 the opcode decodes to nothing.
                if (XLEN == 64) begin
                    if (w_is_shift) begin
                        o_kind_c    = IMM_SHAMT;
                        w_imm64     = 64'(i_inst[24:20]);
                        o_illegal_c = i_inst[25];
                    end else begin
                        o_kind_c = IMM_I;
                        w_imm64  = {{52{w_s}}, i_inst[31:20]};
                    end
                end
            end
            OPC_STORE: begin
                o_kind_c = IMM_S;
                w_imm64  = {{52{w_s}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_BRANCH: begin
                o_kind_c = IMM_B;
                w_imm64  = {{51{w_s}}, w_s, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_kind_c = IMM_U;
                w_imm64  = {{32{w_s}}, i_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                o_kind_c = IMM_J;
                w_imm64  = {{43{w_s}}, w_s, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (w_f3[2]) begin
                    o_kind_c = IMM_ZIMM;
                    w_imm64  = 64'(i_inst[19:15]);
                end
            end
            default: begin
                o_kind_c = IMM_NONE;
            end
        endcase
    end

    assign o_imm_c = w_imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate unit: imm_extract followed by DEPTH valid/ready register stages
// with flush. Each stage advances when empty or when the stage after it takes its entry.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned TAG_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [KIND_W-1:0] out_kind,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag
);

    if (!xlen_legal(XLEN) || (DEPTH < 1) || (DEPTH > 2)) begin : g_param_check
        $error("imm_gen_pipe: unsupported XLEN/DEPTH");
    end

    logic [XLEN-1:0] w_imm;
    imm_kind_e       w_kind;
    logic            w_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_inst      (in_inst),
        .o_imm_c     (w_imm),
        .o_kind_c    (w_kind),
        .o_illegal_c (w_illegal)
    );

    logic [DEPTH-1:0] r_valid;
    logic [XLEN-1:0]  r_imm     [DEPTH];
    imm_kind_e        r_kind    [DEPTH];
    logic [DEPTH-1:0] r_illegal;
    logic [TAG_W-1:0] r_tag     [DEPTH];

    // Per-stage input view: stage 0 fed by the decoder, stage k by stage k-1.
    logic [DEPTH-1:0] w_stg_valid;
    logic [XLEN-1:0]  w_stg_imm     [DEPTH];
    imm_kind_e        w_stg_kind    [DEPTH];
    logic [DEPTH-1:0] w_stg_illegal;
    logic [TAG_W-1:0] w_stg_tag     [DEPTH];
    logic [DEPTH-1:0] w_ready;

    assign w_stg_valid[0]   = in_valid;
    assign w_stg_imm[0]     = w_imm;
    assign w_stg_kind[0]    = w_kind;
    assign w_stg_illegal[0] = w_illegal;
    assign w_stg_tag[0]     = in_tag;

    for (genvar g = 1; g < DEPTH; g++) begin : g_link
        assign w_stg_valid[g]   = r_valid[g-1];
        assign w_stg_imm[g]     = r_imm[g-1];
        assign w_stg_kind[g]    = r_kind[g-1];
        assign w_stg_illegal[g] = r_illegal[g-1];
        assign w_stg_tag[g]     = r_tag[g-1];
    end

    // Ready ripples back from the consumer; accumulated in a local to keep the chain acyclic.
    always_comb begin : ready_chain
        logic v_acc;
        v_acc   = out_ready;
        w_ready = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            v_acc      = v_acc | ~r_valid[k];
            w_ready[k] = v_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid   <= '0;
            r_illegal <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_imm[k]  <= '0;
                r_kind[k] <= IMM_NONE;
                r_tag[k]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_stg_valid[k];
                    if (w_stg_valid[k]) begin
                        r_imm[k]     <= w_stg_imm[k];
                        r_kind[k]    <= w_stg_kind[k];
                        r_illegal[k] <= w_stg_illegal[k];
                        r_tag[k]     <= w_stg_tag[k];
                    end
                end
            end
        end
    end

    assign in_ready    = w_ready[0];
    assign out_valid   = r_valid[DEPTH-1];
    assign out_imm     = r_imm[DEPTH-1];
    assign out_kind    = r_kind[DEPTH-1];
    assign out_illegal = r_illegal[DEPTH-1];
    assign out_tag     = r_tag[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV64/depth1, RV32/depth1, RV64/depth2)
// share one stimulus stream; expected values are hand-derived instruction encodings.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [63:0] a_out_imm;
    logic [2:0]  a_out_kind;
    logic [7:0]  a_out_tag;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_imm;
    logic [2:0]  b_out_kind;
    logic [7:0]  b_out_tag;

    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [63:0] c_out_imm;
    logic [2:0]  c_out_kind;
    logic [7:0]  c_out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .DEPTH(1), .TAG_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_kind(a_out_kind), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(1), .TAG_W(8)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_kind(b_out_kind), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(8)) dut_c (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_imm(c_out_imm), .out_kind(c_out_kind), .out_illegal(c_out_illegal), .out_tag(c_out_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single edge, then check both depth-1 instances.
    task automatic push_chk(input string nm, input logic [31:0] inst, input logic [7:0] tag,
                            input logic [63:0] imm64, input logic [2:0] kind64, input logic ill64,
                            input logic [31:0] imm32, input logic [2:0] kind32, input logic ill32);
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
        chk({nm, "_a_valid"}, 64'(a_out_valid), 64'd1);
        chk({nm, "_a_imm"},   a_out_imm, imm64);
        chk({nm, "_a_kind"},  64'(a_out_kind), 64'(kind64));
        chk({nm, "_a_ill"},   64'(a_out_illegal), 64'(ill64));
        chk({nm, "_a_tag"},   64'(a_out_tag), 64'(tag));
        chk({nm, "_b_imm"},   64'(b_out_imm), 64'(imm32));
        chk({nm, "_b_kind"},  64'(b_out_kind), 64'(kind32));
        chk({nm, "_b_ill"},   64'(b_out_illegal), 64'(ill32));
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_imm",   a_out_imm, 64'd0);
        chk("rst_a_kind",  64'(a_out_kind), 64'd0);
        chk("rst_a_tag",   64'(a_out_tag), 64'd0);
        chk("rst_a_ill",   64'(a_out_illegal), 64'd0);
        chk("rst_c_valid", 64'(c_out_valid), 64'd0);
        chk("rst_c_imm",   c_out_imm, 64'd0);
        rstn = 1'b1;
        #1;
        chk("rst_a_ready", 64'(a_in_ready), 64'd1);
        chk("rst_c_ready", 64'(c_in_ready), 64'd1);

        // Decode patterns, one per immediate form.
        push_chk("addi",  32'hFFF00093, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 3'd1, 1'b0);
        push_chk("srai",  32'h43F0D093, 8'h02, 64'h3F, 3'd6, 1'b0, 32'h1F, 3'd6, 1'b1);
        push_chk("beq",   32'hFE000EE3, 8'h03, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'hFFFF_FFFC, 3'd3, 1'b0);
        push_chk("lui",   32'h800000B7, 8'h04, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000, 3'd4, 1'b0);
        push_chk("csrwi", 32'h340FD0F3, 8'h05, 64'd31, 3'd7, 1'b0, 32'd31, 3'd7, 1'b0);
        push_chk("sw",    32'hFE20AC23, 8'h06, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 32'hFFFF_FFF8, 3'd2, 1'b0);
        push_chk("jal",   32'h001000EF, 8'h07, 64'h800, 3'd5, 1'b0, 32'h800, 3'd5, 1'b0);
        push_chk("slliw", 32'h0200109B, 8'h08, 64'd0, 3'd6, 1'b1, 32'd0, 3'd0, 1'b0);
        push_chk("add",   32'h002081B3, 8'h09, 64'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0);
        step();
        step();
        chk("drain_c_valid", 64'(c_out_valid), 64'd0);

        // Depth-2 backpressure: consumer stalls for 5 edges while 3 entries are offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        in_tag    = 8'h11;
        #1;
        chk("bp_ready0", 64'(c_in_ready), 64'd1);
        step();
        chk("bp_lat2_valid", 64'(c_out_valid), 64'd0);
        in_inst = 32'hFE20AC23;
        in_tag  = 8'h22;
        #1;
        chk("bp_ready1", 64'(c_in_ready), 64'd1);
        step();
        chk("bp_out_valid", 64'(c_out_valid), 64'd1);
        chk("bp_out_tagA",  64'(c_out_tag), 64'h11);
        in_inst = 32'h800000B7;
        in_tag  = 8'h33;
        #1;
        chk("bp_ready_full", 64'(c_in_ready), 64'd0);
        step();
        step();
        step();
        chk("bp_hold_tag",  64'(c_out_tag), 64'h11);
        chk("bp_hold_imm",  c_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bp_hold_rdy",  64'(c_in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(c_in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_tagB",  64'(c_out_tag), 64'h22);
        chk("bp_immB",  c_out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("bp_kindB", 64'(c_out_kind), 64'd2);
        step();
        chk("bp_tagC",  64'(c_out_tag), 64'h33);
        chk("bp_immC",  c_out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("bp_validC", 64'(c_out_valid), 64'd1);
        step();
        chk("bp_empty", 64'(c_out_valid), 64'd0);

        // Flush with two entries in flight and a new instruction offered the same cycle.
        in_valid = 1'b1;
        in_inst  = 32'hFFF00093;
        in_tag   = 8'h41;
        step();
        in_tag = 8'h42;
        step();
        chk("fl_pre_valid", 64'(c_out_valid), 64'd1);
        chk("fl_pre_tag",   64'(c_out_tag), 64'h41);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_tag    = 8'h43;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_c_valid", 64'(c_out_valid), 64'd0);
        chk("fl_a_valid", 64'(a_out_valid), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_c_none", 64'(c_out_valid), 64'd0);

        // Flush on an empty pipe: the accepted-looking handshake is discarded.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 8'h44;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_hs_a_valid", 64'(a_out_valid), 64'd0);
        step();
        chk("fl_hs_c_valid", 64'(c_out_valid), 64'd0);

        // Reset while the depth-2 pipe is full and stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h800000B7;
        in_tag    = 8'h51;
        step();
        in_tag = 8'h52;
        step();
        in_valid = 1'b0;
        chk("rs_pre_valid", 64'(c_out_valid), 64'd1);
        rstn = 1'b0;
        step();
        chk("rs_c_valid", 64'(c_out_valid), 64'd0);
        chk("rs_c_imm",   c_out_imm, 64'd0);
        chk("rs_c_tag",   64'(c_out_tag), 64'd0);
        chk("rs_a_imm",   a_out_imm, 64'd0);
        rstn = 1'b1;
        #1;
        chk("rs_c_ready", 64'(c_in_ready), 64'd1);
        step();
        chk("rs_c_after", 64'(c_out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
